// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Fetch-stage branch prediction backed by a direct-mapped branch target buffer
// (BTB). Each entry has a valid bit, a tag, a target and a 2-bit saturating
// counter. Branches (B, BEQZ, BNEZ, BTEQZ, BTNEZ, JR) are resolved in EX. When
// the outcome disagrees with the prediction carried down from IF, a redirect
// is registered for one cycle. Saturating statistics counters track resolved
// branches and mispredicts.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   if_pc          PC being fetched (lookup address)
//   pred_taken     combinational prediction for if_pc
//   pred_target    predicted target, 0 when pred_taken is low
//   ex_valid       a real instruction occupies EX this cycle
//   ex_opn         instruction word in EX
//   ex_pc          address of the EX instruction
//   ex_op1         forwarded rx value
//   ex_t           forwarded T register value
//   ex_pred_taken  prediction that travelled with the EX instruction
//   ex_pred_target predicted target that travelled with the EX instruction
//   set_pc         registered one-cycle redirect request
//   set_pc_value   registered redirect address (holds between redirects)
//   branch_cnt     resolved branch count, saturating
//   mispred_cnt    mispredict count, saturating
//
// Redirect semantics: set_pc is a single-cycle pulse with no back-pressure;
// the consumer must accept it in the cycle it is high and squash the
// instruction that follows. This unit never gates ex_valid itself.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int         WIDTH    = 16,
    parameter int         IDX_BITS = 4,
    parameter int         TAG_BITS = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] if_pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             ex_valid,
    input  logic [15:0]      ex_opn,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_op1,
    input  logic [WIDTH-1:0] ex_t,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_pred_target,
    output logic             set_pc,
    output logic [WIDTH-1:0] set_pc_value,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispred_cnt
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_LO  = IDX_BITS;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS - 1;

    // BTB storage
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [WIDTH-1:0]    target_q [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];

    // ---------------- Fetch-side lookup (no bypass from EX update) ----------
    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic                if_hit;

    assign if_idx      = if_pc[IDX_BITS-1:0];
    assign if_tag      = if_pc[TAG_HI:TAG_LO];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && cnt_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : '0;

    // PC bits above the tag field take no part in lookup.
    generate
        if (IDX_BITS + TAG_BITS < WIDTH) begin : g_unused_hi
            logic unused_if_hi;
            assign unused_if_hi = ^if_pc[WIDTH-1:IDX_BITS+TAG_BITS];
        end
    endgenerate

    // ---------------- EX decode and resolution ------------------------------
    logic             is_b, is_beqz, is_bnez, is_bteqz, is_btnez, is_jr;
    logic             is_cond, is_branch;
    logic             taken, mispredict;
    logic [WIDTH-1:0] pc1, off11, off8, target, actual_next;

    assign pc1      = ex_pc + {{(WIDTH-1){1'b0}}, 1'b1};
    assign off11    = {{(WIDTH-11){ex_opn[10]}}, ex_opn[10:0]};
    assign off8     = {{(WIDTH-8){ex_opn[7]}}, ex_opn[7:0]};

    assign is_b     = (ex_opn[15:11] == 5'b00010);
    assign is_beqz  = (ex_opn[15:11] == 5'b00100);
    assign is_bnez  = (ex_opn[15:11] == 5'b00101);
    assign is_bteqz = (ex_opn[15:8]  == 8'b01100000);
    assign is_btnez = (ex_opn[15:8]  == 8'b01100001);
    assign is_jr    = (ex_opn[15:11] == 5'b11101) && (ex_opn[7:0] == 8'h00);

    assign is_cond   = is_beqz || is_bnez || is_bteqz || is_btnez;
    assign is_branch = is_cond || is_b || is_jr;

    always_comb begin
        taken  = 1'b0;
        target = pc1 + off8;
        if (is_b) begin
            taken  = 1'b1;
            target = pc1 + off11;
        end else if (is_jr) begin
            taken  = 1'b1;
            target = ex_op1;
        end else if (is_beqz) begin
            taken = (ex_op1 == '0);
        end else if (is_bnez) begin
            taken = (ex_op1 != '0);
        end else if (is_bteqz) begin
            taken = (ex_t == '0);
        end else if (is_btnez) begin
            taken = (ex_t != '0);
        end
    end

    assign actual_next = taken ? target : pc1;

    // A non-branch has taken=0, so a stale taken prediction on it (alias)
    // falls out of the direction-mismatch term.
    assign mispredict = ex_valid &&
                        ((taken != ex_pred_taken) ||
                         (taken && (ex_pred_target != target)));

    // ---------------- EX-side BTB probe -------------------------------------
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] ex_tag;
    logic                ex_hit;

    assign ex_idx = ex_pc[IDX_BITS-1:0];
    assign ex_tag = ex_pc[TAG_HI:TAG_LO];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // ---------------- State update ------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_pc       <= 1'b0;
            set_pc_value <= '0;
            branch_cnt   <= '0;
            mispred_cnt  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b00;
            end
        end else begin
            set_pc <= mispredict;
            if (mispredict) begin
                set_pc_value <= actual_next;
            end

            if (ex_valid) begin
                if (is_branch && (branch_cnt != 16'hffff)) begin
                    branch_cnt <= branch_cnt + 16'd1;
                end
                if (mispredict && (mispred_cnt != 16'hffff)) begin
                    mispred_cnt <= mispred_cnt + 16'd1;
                end

                if (is_branch && taken) begin
                    if (ex_hit) begin
                        if (cnt_q[ex_idx] != 2'b11) begin
                            cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'b01;
                        end
                        target_q[ex_idx] <= target;
                    end else begin
                        // Unconditional jumps start strongly taken.
                        valid_q[ex_idx]  <= 1'b1;
                        tag_q[ex_idx]    <= ex_tag;
                        target_q[ex_idx] <= target;
                        cnt_q[ex_idx]    <= (is_b || is_jr) ? 2'b11 : CNT_INIT;
                    end
                end else if (is_cond) begin
                    if (ex_hit && (cnt_q[ex_idx] != 2'b00)) begin
                        cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'b01;
                    end
                end else if (!is_branch && ex_hit) begin
                    // A non-branch matching an entry means a stale alias.
                    valid_q[ex_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational jump controller.
- Predicts branches at fetch using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves B, BEQZ, BNEZ, BTEQZ, BTNEZ and JR in EX, issuing a registered redirect on mispredict.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- WIDTH, 16, data/PC width.
- IDX_BITS, 4, BTB index bits; ENTRIES = 2**IDX_BITS.
- TAG_BITS, 6, tag bits taken from pc[IDX_BITS+TAG_BITS-1:IDX_BITS]; IDX_BITS+TAG_BITS <= WIDTH.
- CNT_INIT, 2'b01, counter value written on entry allocation for conditional branches.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  WIDTH  PC being fetched.
- pred_taken  out  1  combinational prediction for if_pc.
- pred_target  out  WIDTH  predicted target; 0 when pred_taken=0.
- ex_valid  in  1  a real instruction is in EX this cycle; low for bubbles and stalls.
- ex_opn  in  16  instruction word in EX.
- ex_pc  in  WIDTH  address of the EX instruction.
- ex_op1  in  WIDTH  rx value, already forwarded.
- ex_t  in  WIDTH  T register value, already forwarded.
- ex_pred_taken  in  1  pred_taken carried with the instruction from IF.
- ex_pred_target  in  WIDTH  pred_target carried with the instruction from IF.
- set_pc  out  1  registered redirect request.
- set_pc_value  out  WIDTH  registered redirect address.
- branch_cnt  out  16  resolved branch count, saturating at 16'hffff.
- mispred_cnt  out  16  mispredict count, saturating at 16'hffff.

Behaviour:
- Reset (rst=0, asynchronous):
  - set_pc=0, set_pc_value=0, branch_cnt=0, mispred_cnt=0.
  - All BTB valid bits cleared; counters set to 2'b00.
  - Reset mid-redirect discards the pending redirect.
- Lookup (combinational from registered table):
  - idx = if_pc[IDX_BITS-1:0].
  - hit = valid[idx] && tag[idx] == if_pc tag field.
  - pred_taken = hit && cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : 0.
- Decode in EX:
  - pc1 = ex_pc + 1.
  - B: opn[15:11]=00010; always taken; target = pc1 + sext(opn[10:0]).
  - BEQZ: opn[15:11]=00100; taken iff ex_op1==0; target = pc1 + sext(opn[7:0]).
  - BNEZ: opn[15:11]=00101; taken iff ex_op1!=0; same target form as BEQZ.
  - BTEQZ: opn[15:8]=01100000; taken iff ex_t==0; same target form.
  - BTNEZ: opn[15:8]=01100001; taken iff ex_t!=0; same target form.
  - JR: opn[15:11]=11101 and opn[7:0]=0; always taken; target = ex_op1.
  - Any other opcode is a non-branch.
- Outcome: actual_next = taken ? target : pc1, computed modulo 2**WIDTH.
- Mispredict when ex_valid and any of:
  - taken != ex_pred_taken;
  - taken and ex_pred_target != target;
  - non-branch with ex_pred_taken=1 (alias).
- Redirect timing:
  - On mispredict, set_pc=1 and set_pc_value=actual_next on the next rising edge, for exactly one cycle.
  - Otherwise set_pc=0 and set_pc_value holds its last value.
- Table update at the same edge, only when ex_valid; eidx = ex_pc index field:
  - Taken branch, miss: allocate with valid=1, tag, target. Counter = 2'b11 for B/JR, CNT_INIT for conditionals.
  - Taken branch, hit: counter +1, saturating at 11; target rewritten.
  - Not-taken conditional, hit: counter -1, saturating at 00. Miss: no allocation.
  - Alias non-branch that hit: valid[eidx] cleared.
- Statistics:
  - branch_cnt +1 per resolved branch with ex_valid.
  - mispred_cnt +1 per mispredict.
  - Both hold at 16'hffff.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
- ex_valid=0: no update, no redirect, no counting, whatever ex_opn holds.
- The pipeline must squash the following instruction in the cycle set_pc=1; this unit does not gate ex_valid.

Test Plan:
- Reset: rst=0 -> set_pc=0, counters 0, pred_taken=0 for if_pc=0..15.
- Cold B: ex_pc=0x0010, opn=0x17FE (B -2), ex_pred_taken=0 -> next cycle set_pc=1, value=0x000F; if_pc=0x0010 then gives pred_taken=1, target=0x000F; branch_cnt=1, mispred_cnt=1.
- BNEZ training:
  - Repeat ex_pc=0x0020, opn=0x2905 with ex_op1=3, feeding back pred_taken/target.
  - First pass mispredicts to 0x0026 and installs counter=01, so pred stays 0.
  - Second pass mispredicts again, counter -> 10.
  - Third pass predicted correctly, set_pc=0.
  - Then ex_op1=0 -> redirect to 0x0021, counter -> 01.
- BTEQZ/BTNEZ: opn=0x6003/0x6103 with ex_t=0, pred 0 -> redirect 0x(pc+4) for BTEQZ only.
- JR: opn=0xED00, ex_op1=0x1234, pred_taken=1 with pred_target=0x1200 -> redirect 0x1234; entry target updated to 0x1234.
- Alias and edges:
  - Non-branch with ex_pred_taken=1 at ex_pc=0x0030 -> redirect 0x0031, entry invalidated.
  - ex_valid=0 with a branch opcode -> no effect.
  - Mispred_cnt preset near saturation holds at 0xFFFF.
  - Async reset asserted while set_pc=1 -> set_pc drops immediately.
